// File: rtl/snr_cal_sequencer_pkg.sv
// Shared types for the SNR calibration sequencer and the logic that observes it
// (display, debug).
//   cal_state_t : sequencer state encoding
//   max_u       : larger of two unsigned values, used when sizing shared counters
package snr_cal_pkg;

    typedef enum logic [1:0] {
        SETTLE = 2'd0,
        QUIET  = 2'd1,
        RUN    = 2'd2,
        ERROR  = 2'd3
    } cal_state_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/snr_cal_sequencer_if.sv
// Valid/ready sample stream used on both sides of the sequencer.
//   data  : sample value, meaningful while valid is high
//   valid : producer has a sample
//   ready : consumer can take it
// master drives data/valid and observes ready; slave does the opposite.
interface snr_cal_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 16
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/snr_cal_sequencer_timer.sv
// Free-running cycle timer with synchronous clear and a terminal-count compare.
// The sequencer shares one instance between the settle delay and the
// quiet-phase stall timeout.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force the count to zero (takes priority over enable)
//   enable     : advance the count by one
//   terminal   : compare value
//   at_term_c  : combinational, high while count == terminal
module cycle_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] terminal,
    output logic             at_term_c
);

    logic [WIDTH-1:0] count;

    // Count register
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + WIDTH'(1);
        end
    end

    assign at_term_c = (count == terminal);

endmodule

// File: rtl/snr_cal_sequencer.sv
// Sequences the SNR calculator: holds off after reset while the codec is
// configured, runs a quiet-period noise calibration over CAL_SAMPLES accepted
// samples, then passes samples through for measurement. Supports on-demand
// recalibration and flags an input stream that stalls during calibration.
//   clk, reset   : clock, synchronous active-high reset
//   recal_req    : single-cycle recalibration request
//   up           : stream from upstream (in_data / in_valid / in_ready)
//   down         : stream to snr_calculator (out_data / out_valid / out_ready)
//   quiet_period : to snr_calculator, high while calibrating
//   cal_active   : high while calibrating
//   cal_done     : one-cycle pulse on the first cycle of RUN
//   cal_error    : high while in ERROR
//   cal_count    : samples accepted in the current calibration
module snr_cal_sequencer
    import snr_cal_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned SETTLE_CYCLES  = 50_000_000,
    parameter int unsigned CAL_SAMPLES    = 48_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    localparam int unsigned CNT_W         = $clog2(CAL_SAMPLES + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 recal_req,
    snr_cal_sequencer_if.slave   up,
    snr_cal_sequencer_if.master  down,
    output logic                 quiet_period,
    output logic                 cal_active,
    output logic                 cal_done,
    output logic                 cal_error,
    output logic [CNT_W-1:0]     cal_count
);

    localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TMR_W = max_u(SET_W, TO_W);

    cal_state_t            state;
    cal_state_t            state_nxt;
    logic [CNT_W-1:0]      count_nxt;
    logic                  pass_c;
    logic                  accept_c;
    logic                  tmr_clear;
    logic                  tmr_en;
    logic [TMR_W-1:0]      tmr_term;
    logic                  tmr_at_term_c;
    logic [DATA_WIDTH-1:0] data_c;

    // Stream gating: passthrough while calibrating or measuring, otherwise
    // samples are consumed and dropped so upstream never backs up.
    assign pass_c     = (state == QUIET) || (state == RUN);
    assign data_c     = up.data;
    assign down.data  = data_c;
    assign down.valid = pass_c & up.valid;
    assign up.ready   = pass_c ? down.ready : 1'b1;
    assign accept_c   = (state == QUIET) & up.valid & down.ready;

    // Settle delay and stall timeout never run together, so one timer serves both
    cycle_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (tmr_clear),
        .enable    (tmr_en),
        .terminal  (tmr_term),
        .at_term_c (tmr_at_term_c)
    );

    // Next-state, sample-count and timer control
    always_comb begin
        state_nxt = state;
        count_nxt = cal_count;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;
        tmr_term  = TMR_W'(SETTLE_CYCLES - 1);
        case (state)
            SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_at_term_c) begin
                    state_nxt = QUIET;
                    tmr_clear = 1'b1;
                    count_nxt = '0;
                end
            end
            QUIET: begin
                tmr_term = TMR_W'(TIMEOUT_CYCLES - 1);
                tmr_en   = 1'b1;
                // Priority: recal, then accept, then timeout. The sample that
                // coincides with a recal is forwarded but not counted.
                if (recal_req) begin
                    tmr_clear = 1'b1;
                    count_nxt = '0;
                end else if (accept_c) begin
                    tmr_clear = 1'b1;
                    if (cal_count != CNT_W'(CAL_SAMPLES)) begin
                        count_nxt = cal_count + CNT_W'(1);
                    end
                    if (cal_count >= CNT_W'(CAL_SAMPLES - 1)) begin
                        state_nxt = RUN;
                    end
                end else if (tmr_at_term_c) begin
                    state_nxt = ERROR;
                    tmr_clear = 1'b1;
                end
            end
            RUN, ERROR: begin
                if (recal_req) begin
                    state_nxt = QUIET;
                    tmr_clear = 1'b1;
                    count_nxt = '0;
                end
            end
            default: begin
                state_nxt = SETTLE;
                tmr_clear = 1'b1;
                count_nxt = '0;
            end
        endcase
    end

    // State and status registers; status decodes the next state so it lines
    // up with the state it describes.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= SETTLE;
            cal_count    <= '0;
            quiet_period <= 1'b0;
            cal_active   <= 1'b0;
            cal_done     <= 1'b0;
            cal_error    <= 1'b0;
        end else begin
            state        <= state_nxt;
            cal_count    <= count_nxt;
            quiet_period <= (state_nxt == QUIET);
            cal_active   <= (state_nxt == QUIET);
            cal_done     <= (state == QUIET) && (state_nxt == RUN);
            cal_error    <= (state_nxt == ERROR);
        end
    end

endmodule

// File: tb/tb_snr_cal_sequencer.sv
// Directed bench for snr_cal_sequencer with SETTLE_CYCLES=10, CAL_SAMPLES=8,
// TIMEOUT_CYCLES=20. A hand-written power-up sequence is followed by a table
// of per-cycle {inputs, expected outputs} records.
module tb_snr_cal_sequencer;

    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic          recal_req;
    logic          quiet_period;
    logic          cal_active;
    logic          cal_done;
    logic          cal_error;
    logic [CW-1:0] cal_count;

    snr_cal_sequencer_if #(.DATA_WIDTH(DW)) up_if ();
    snr_cal_sequencer_if #(.DATA_WIDTH(DW)) dn_if ();

    snr_cal_sequencer #(
        .DATA_WIDTH     (DW),
        .SETTLE_CYCLES  (10),
        .CAL_SAMPLES    (8),
        .TIMEOUT_CYCLES (20)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .recal_req    (recal_req),
        .up           (up_if),
        .down         (dn_if),
        .quiet_period (quiet_period),
        .cal_active   (cal_active),
        .cal_done     (cal_done),
        .cal_error    (cal_error),
        .cal_count    (cal_count)
    );

    typedef struct {
        logic          rst;
        logic          recal;
        logic          iv;
        logic          ordy;
        logic [DW-1:0] data;
        logic          ov;
        logic          ir;
        logic          qp;
        logic          dn;
        logic          er;
        logic [CW-1:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   n_checks;
    int   n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic recal, input logic iv, input logic ordy,
                       input logic ov, input logic ir, input logic qp, input logic dn,
                       input logic er, input int cnt);
        vec_t v;
        v.rst   = rst;
        v.recal = recal;
        v.iv    = iv;
        v.ordy  = ordy;
        v.data  = DW'($urandom);
        v.ov    = ov;
        v.ir    = ir;
        v.qp    = qp;
        v.dn    = dn;
        v.er    = er;
        v.cnt   = CW'(cnt);
        vecs.push_back(v);
    endtask

    // QUIET cycles without a handshake (nothing offered)
    task automatic idle_q(input int n, input int cnt);
        for (int i = 0; i < n; i++) add(0, 0, 0, 1, 0, 1, 1, 0, 0, cnt);
    endtask

    // QUIET cycles with a sample offered but downstream not ready
    task automatic stall_q(input int n, input int cnt);
        for (int i = 0; i < n; i++) add(0, 0, 1, 0, 1, 0, 1, 0, 0, cnt);
    endtask

    // QUIET cycles with a handshake every cycle, count visible before each accept
    task automatic accept_q(input int n, input int start);
        for (int i = 0; i < n; i++) add(0, 0, 1, 1, 1, 1, 1, 0, 0, start + i);
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        reset       = v.rst;
        recal_req   = v.recal;
        up_if.valid = v.iv;
        up_if.data  = v.data;
        dn_if.ready = v.ordy;
        #1;
        chk("out_valid", idx, 32'(dn_if.valid), 32'(v.ov));
        chk("in_ready", idx, 32'(up_if.ready), 32'(v.ir));
        chk("quiet_period", idx, 32'(quiet_period), 32'(v.qp));
        chk("cal_active", idx, 32'(cal_active), 32'(v.qp));
        chk("cal_done", idx, 32'(cal_done), 32'(v.dn));
        chk("cal_error", idx, 32'(cal_error), 32'(v.er));
        chk("cal_count", idx, 32'(cal_count), 32'(v.cnt));
        if (v.ov) chk("out_data", idx, 32'(dn_if.data), 32'(v.data));
    endtask

    initial begin
        int n;
        int m;
        n_checks    = 0;
        n_fail      = 0;
        reset       = 1'b1;
        recal_req   = 1'b0;
        up_if.valid = 1'b1;
        up_if.data  = '0;
        dn_if.ready = 1'b1;

        // Power-up: settle length and first calibration, input valid every cycle
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_quiet", 0, 32'(quiet_period), 0);
        chk("rst_count", 0, 32'(cal_count), 0);
        chk("rst_error", 0, 32'(cal_error), 0);
        n = 0;
        while (!quiet_period && n < 100) begin
            chk("settle_ov", n, 32'(dn_if.valid), 0);
            chk("settle_ir", n, 32'(up_if.ready), 1);
            @(negedge clk);
            up_if.data = DW'(n + 16'h100);
            #1;
            n++;
        end
        chk("settle_len", 0, 32'(n), 10);
        m = 0;
        while (!cal_done && m < 100) begin
            chk("cal_ov", m, 32'(dn_if.valid), 1);
            chk("cal_qp", m, 32'(quiet_period), 1);
            @(negedge clk);
            #1;
            m++;
        end
        chk("cal_len", 0, 32'(m), 8);
        chk("done_count", 0, 32'(cal_count), 8);
        chk("done_qp", 0, 32'(quiet_period), 0);
        @(negedge clk);
        #1;
        chk("done_pulse", 0, 32'(cal_done), 0);
        chk("run_count", 0, 32'(cal_count), 8);

        // Reset mid-RUN, then a full settle with recal ignored
        add(1, 0, 1, 1, 1, 1, 0, 0, 0, 8);
        for (int i = 0; i < 10; i++) add(0, (i == 3), 1, 1'(i % 2), 0, 1, 0, 0, 0, 0);
        // Calibration to RUN
        accept_q(8, 0);
        add(0, 0, 0, 1, 0, 1, 0, 1, 0, 8);
        add(0, 0, 1, 0, 1, 0, 0, 0, 0, 8);
        // Recal from RUN
        add(0, 1, 1, 1, 1, 1, 0, 0, 0, 8);
        idle_q(1, 0);
        // Recal coinciding with the final accept: no done, count restarts
        accept_q(7, 0);
        add(0, 1, 1, 1, 1, 1, 1, 0, 0, 7);
        idle_q(1, 0);
        accept_q(8, 0);
        add(0, 0, 1, 1, 1, 1, 0, 1, 0, 8);
        add(0, 1, 0, 1, 0, 1, 0, 0, 0, 8);
        // Timeout boundary: accept on the 20th idle cycle, then 19-cycle spacing
        idle_q(19, 0);
        accept_q(1, 0);
        idle_q(18, 1);
        accept_q(1, 1);
        stall_q(19, 2);
        accept_q(1, 2);
        // Recal wins over timeout
        idle_q(19, 3);
        add(0, 1, 0, 1, 0, 1, 1, 0, 0, 3);
        idle_q(19, 0);
        accept_q(1, 0);
        // Downstream stalled: ERROR after 20 cycles, then recal out of it
        stall_q(20, 1);
        for (int i = 0; i < 10; i++) add(0, 0, 1, 0, 0, 1, 0, 0, 1, 1);
        add(0, 1, 1, 0, 0, 1, 0, 0, 1, 1);
        idle_q(1, 0);
        // Reset mid-QUIET with count 5
        accept_q(5, 0);
        add(1, 0, 1, 1, 1, 1, 1, 0, 0, 5);
        add(0, 0, 1, 1, 0, 1, 0, 0, 0, 0);
        add(0, 1, 1, 0, 0, 1, 0, 0, 0, 0);

        foreach (vecs[i]) apply(vecs[i], i);

        @(negedge clk);
        reset     = 1'b0;
        recal_req = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
